// File: rtl/dct_quant_stage.sv
// Quantize/dequantize stage between the forward dct and the idct.
// Captures 64-coefficient blocks into ping-pong banks and re-streams them with a done window.
//
// rd_state | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for the bank at rd_bank to become full
// DRAIN    | presenting bank[rd_bank][rd_cnt] on dout with done=1
// GAP      | single done=0 cycle between consecutive output windows
module dct_quant_stage #(
    parameter int BitWidth = 31,
    parameter int COEF_W   = 14,
    parameter int QBIAS    = 0,
    parameter int BLOCK    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din_valid,
    input  logic [BitWidth:0] din,
    output logic              done,
    output logic [BitWidth:0] dout,
    output logic              overrun,
    output logic [4:0]        state_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        GAP   = 2'd2
    } rd_state_t;

    localparam int DW = COEF_W + 8;
    localparam logic [5:0] LAST = 6'(BLOCK - 1);
    localparam logic signed [DW-1:0] SAT_MAX = DW'((2 ** (COEF_W - 1)) - 1);
    localparam logic signed [DW-1:0] SAT_MIN = DW'(-(2 ** (COEF_W - 1)));

    rd_state_t rd_state;
    logic       wr_bank;
    logic       rd_bank;
    logic [5:0] wr_cnt;
    logic [5:0] rd_cnt;
    logic [1:0] full;
    logic       skip;

    logic signed [COEF_W-1:0] mem [0:2*BLOCK-1];
    logic signed [COEF_W-1:0] rd_word;

    logic signed [COEF_W-1:0] coef;
    logic signed [COEF_W-1:0] coef_q;
    logic [3:0]               pos_sum;
    logic [31:0]              s_raw;
    logic [2:0]               shift;
    logic signed [COEF_W:0]   rnd;
    logic signed [COEF_W:0]   sum_cr;
    logic signed [COEF_W:0]   q_val;
    logic signed [DW-1:0]     d_ext;
    logic signed [DW-1:0]     d_full;

    logic       wr_en;
    logic       ovr_hit;
    logic [1:0] set_mask;
    logic [1:0] clr_mask;
    logic       unused_din;

    assign unused_din = ^din[BitWidth-COEF_W:0];

    // Step grows with distance from DC: shift = (row+col)/2 + QBIAS, capped at 7.
    always_comb begin
        coef    = din[BitWidth -: COEF_W];
        pos_sum = {1'b0, wr_cnt[5:3]} + {1'b0, wr_cnt[2:0]};
        s_raw   = 32'(pos_sum >> 1) + 32'(QBIAS);
        shift   = (s_raw > 32'd7) ? 3'd7 : s_raw[2:0];
        rnd     = (shift == 3'd0) ? '0 : ((COEF_W+1)'(1) << (shift - 3'd1));
        sum_cr  = $signed({coef[COEF_W-1], coef}) + rnd;
        q_val   = sum_cr >>> shift;
        d_ext   = {{(DW-COEF_W-1){q_val[COEF_W]}}, q_val};
        d_full  = d_ext <<< shift;
        if (d_full > SAT_MAX) begin
            coef_q = SAT_MAX[COEF_W-1:0];
        end else if (d_full < SAT_MIN) begin
            coef_q = SAT_MIN[COEF_W-1:0];
        end else begin
            coef_q = d_full[COEF_W-1:0];
        end
    end

    // A window that opens onto a still-full bank is dropped in its entirety.
    always_comb begin
        ovr_hit  = din_valid && !skip && (wr_cnt == 6'd0) && full[wr_bank];
        wr_en    = din_valid && !skip && !ovr_hit;
        set_mask = (wr_en && wr_cnt == LAST) ? (2'b01 << wr_bank) : 2'b00;
        clr_mask = (rd_state == DRAIN && rd_cnt == LAST) ? (2'b01 << rd_bank) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_cnt}] <= coef_q;
        end
    end

    assign rd_word   = mem[{rd_bank, rd_cnt}];
    assign state_out = {wr_bank, rd_bank, rd_state, overrun};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state <= IDLE;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            full     <= 2'b00;
            skip     <= 1'b0;
            overrun  <= 1'b0;
            done     <= 1'b0;
            dout     <= '0;
        end else begin
            full <= (full & ~clr_mask) | set_mask;

            if (!din_valid) begin
                wr_cnt <= '0;
                skip   <= 1'b0;
            end else if (ovr_hit) begin
                overrun <= 1'b1;
                skip    <= 1'b1;
            end else if (wr_en) begin
                if (wr_cnt == LAST) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + 6'd1;
                end
            end

            case (rd_state)
                IDLE: begin
                    done <= 1'b0;
                    if (full[rd_bank]) begin
                        rd_state <= DRAIN;
                        rd_cnt   <= '0;
                    end
                end
                DRAIN: begin
                    done <= 1'b1;
                    dout <= {{(BitWidth+1-COEF_W){rd_word[COEF_W-1]}}, rd_word};
                    if (rd_cnt == LAST) begin
                        rd_cnt   <= '0;
                        rd_bank  <= ~rd_bank;
                        rd_state <= GAP;
                    end else begin
                        rd_cnt <= rd_cnt + 6'd1;
                    end
                end
                GAP: begin
                    done     <= 1'b0;
                    rd_state <= full[rd_bank] ? DRAIN : IDLE;
                end
                default: begin
                    done     <= 1'b0;
                    rd_state <= IDLE;
                end
            endcase
        end
    end

endmodule
